// File: rtl/memory_stage.sv
// Memory (M) stage of the 5-stage RISC-V pipeline: drives a variable-latency
// data port through a req/ready handshake and registers results into M/W.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    output logic        Stall,
    output logic        MisalignM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_r;
    logic        memop_s;
    logic        is_load_s;
    logic        misalign_s;
    logic        access_s;
    logic [31:0] load_data_s;

    // Select the addressed byte/half from the aligned word and extend it.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'h000000, b};
            3'b101:  extend_load = {16'h0000, h};
            default: extend_load = word;
        endcase
    endfunction

    assign memop_s     = (ResultSrcM == 2'b01) | MemWriteM;
    assign is_load_s   = (ResultSrcM == 2'b01);
    assign access_s    = memop_s & ~misalign_s;
    assign load_data_s = extend_load(Funct3M, ALUResultM[1:0], mem_rdata);

    // Alignment check; only meaningful for memory operations.
    always_comb begin
        misalign_s = 1'b0;
        if (memop_s) begin
            case (Funct3M[1:0])
                2'b01:   misalign_s = ALUResultM[0];
                2'b10:   misalign_s = |ALUResultM[1:0];
                default: misalign_s = 1'b0;
            endcase
        end else begin
            misalign_s = 1'b0;
        end
    end

    assign MisalignM = misalign_s;
    // The pipeline ahead is frozen while WAIT, so access_s stays true there.
    assign mem_req   = ~rst & ((state_r == WAIT) | access_s);
    assign Stall     = ~rst & access_s & ~mem_ready;
    assign mem_we    = MemWriteM;
    assign mem_addr  = {ALUResultM[31:2], 2'b00};

    // Store lane replication and byte enables; loads read the full word.
    always_comb begin
        mem_wdata = WriteDataM;
        mem_be    = 4'b1111;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    mem_wdata = {4{WriteDataM[7:0]}};
                    mem_be    = 4'b0001 << ALUResultM[1:0];
                end
                2'b01: begin
                    mem_wdata = {2{WriteDataM[15:0]}};
                    mem_be    = 4'b0011 << ALUResultM[1:0];
                end
                default: begin
                    mem_wdata = WriteDataM;
                    mem_be    = 4'b1111;
                end
            endcase
        end else begin
            mem_wdata = WriteDataM;
            mem_be    = 4'b1111;
        end
    end

    // Handshake FSM: leave IDLE only when the access did not finish at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= (access_s && !mem_ready) ? WAIT : IDLE;
                WAIT:    state_r <= mem_ready ? IDLE : WAIT;
                default: state_r <= IDLE;
            endcase
        end
    end

    // M/W pipeline register: bubble on stall, squash write on misalignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'h0000_0000;
            ReadDataW  <= 32'h0000_0000;
            RdW        <= 5'd0;
        end else if (Stall) begin
            RegWriteW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~misalign_s;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (is_load_s && !misalign_s) ? load_data_s : 32'h0000_0000;
            RdW        <= RdM;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage: a driver with a word-array
// memory model pushes expected M/W contents, a monitor pops and compares.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM, MemWriteM, Stall, MisalignM, mem_req, mem_we, mem_ready;
    logic [1:0]  ResultSrcM, ResultSrcW;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, mem_addr, mem_wdata, mem_rdata, ALUResultW, ReadDataW;
    logic [4:0]  RdM, RdW;
    logic [3:0]  mem_be;
    logic        RegWriteW;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .Stall(Stall), .MisalignM(MisalignM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rd_valid;
        logic [4:0]  rd;
    } wexp_t;

    wexp_t       q[$];
    wexp_t       last;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:255];
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wexp_t zero_exp();
        wexp_t e;
        e.rw = 1'b0; e.rs = 2'b00; e.alu = 32'h0; e.rdata = 32'h0; e.rd_valid = 1'b1; e.rd = 5'd0;
        return e;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Loaded value: shift the word down by the byte offset, truncate to size, extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int          sz;
        int          off;
        logic [31:0] w;
        longint      val;
        sz  = size_of(f3);
        off = addr % 4;
        if (sz >= 4) return word;
        w   = word >> (8 * off);
        val = longint'(w) % (longint'(1) << (8 * sz));
        if (!f3[2] && val >= (longint'(1) << (8 * sz - 1)))
            val = val - (longint'(1) << (8 * sz));
        return val[31:0];
    endfunction

    task automatic issue(input logic regw, input logic [1:0] rsrc, input logic memw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input int waits);
        int          sz, off, n;
        bit          memop, mis, active;
        wexp_t       e;
        logic [31:0] word, ewd;
        logic [3:0]  ebe;
        sz     = size_of(f3);
        off    = addr % 4;
        memop  = (rsrc == 2'b01) || memw;
        mis    = memop && (addr % sz != 0);
        active = memop && !mis;
        n      = active ? waits : 0;
        RegWriteM = regw; ResultSrcM = rsrc; MemWriteM = memw; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd;
        word = mem[addr[9:2]];
        for (int i = 0; i < 4; i++) begin
            ebe[i] = (sz >= 4) || (i >= off && i < off + sz);
            ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        e.rw = regw && !mis; e.rs = rsrc; e.alu = addr; e.rd = rd; e.rd_valid = !mis;
        e.rdata = (rsrc == 2'b01 && !mis) ? ref_load(f3, addr, word) : 32'h0;
        for (int k = 0; k <= n; k++) begin
            mem_ready = active ? (k == n) : ($urandom_range(0, 1) == 1);
            mem_rdata = (active && k == n) ? word : $urandom;
            #1;
            check("stall", Stall, active && k < n);
            check("misalign", MisalignM, mis);
            check("mem_req", mem_req, active);
            if (active) begin
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_we", mem_we, memw);
                if (memw) begin
                    check("mem_be", mem_be, ebe);
                    check("mem_wdata", mem_wdata, ewd);
                end
            end
            if (k == n) begin
                if (active && memw)
                    for (int i = 0; i < 4; i++)
                        if (ebe[i]) mem[addr[9:2]][8*i +: 8] = ewd[8*i +: 8];
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every non-reset edge either bubbles (Stall) or retires one entry.
    initial begin
        logic  st, r;
        wexp_t e;
        last = zero_exp();
        forever begin
            @(posedge clk);
            st = Stall;
            r  = rst;
            #1;
            if (r || rst) begin
                last = zero_exp();
            end else if (st) begin
                check("bubble_regwrite", RegWriteW, 1'b0);
                check("hold_alu", ALUResultW, last.alu);
                check("hold_rd", RdW, last.rd);
                check("hold_src", ResultSrcW, last.rs);
                check("hold_rdata", ReadDataW, last.rdata);
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w_update: W advanced with no expected entry at %0t", $time);
            end else begin
                e = q.pop_front();
                check("w_regwrite", RegWriteW, e.rw);
                check("w_src", ResultSrcW, e.rs);
                check("w_alu", ALUResultW, e.alu);
                check("w_rd", RdW, e.rd);
                if (e.rd_valid) check("w_rdata", ReadDataW, e.rdata);
                else e.rdata = ReadDataW;
                last = e;
            end
        end
    end

    initial begin
        int          guard;
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'h0; RdM = 5'd1; mem_ready = 1'b0; mem_rdata = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_stall", Stall, 1'b0);
        check("rst_regwrite", RegWriteW, 1'b0);
        check("rst_src", ResultSrcW, 2'b00);
        check("rst_alu", ALUResultW, 32'h0);
        check("rst_rdata", ReadDataW, 32'h0);
        check("rst_rd", RdW, 5'd0);
        rst = 1'b0;

        issue(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 0);
        check("alu_rd", RdW, 5'd5);
        mem[32'h40] = 32'hDEADBEEF;
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd6, 0);
        check("lw_rdata", ReadDataW, 32'hDEADBEEF);
        mem[32'h40] = 32'h80FFFFFF;
        issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 3);
        check("lb_rdata", ReadDataW, 32'hFFFFFF80);
        issue(1'b1, 2'b01, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 3);
        check("lbu_rdata", ReadDataW, 32'h00000080);
        issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'hAAAA5555, 5'd0, 1);
        issue(1'b0, 2'b00, 1'b1, 3'b000, 32'h201, 32'h000000C3, 5'd0, 0);
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 5'd9, 2);
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 5'd10, 0);
        check("mis_regwrite", RegWriteW, 1'b0);

        // Reset arriving while a load waits abandons it.
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h104; RdM = 5'd11; mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("wait_req", mem_req, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rstwait_req", mem_req, 1'b0);
        check("rstwait_stall", Stall, 1'b0);
        check("rstwait_regwrite", RegWriteW, 1'b0);
        check("rstwait_alu", ALUResultW, 32'h0);
        check("rstwait_rd", RdW, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h108, 32'h0, 5'd12, 2);
        issue(1'b1, 2'b10, 1'b0, 3'b000, 32'h00000404, 32'h0, 5'd13, 0);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom_range(0, 1023);
            case (kind)
                0: issue($urandom_range(0, 1) == 1, 2'b00, 1'b0, 3'($urandom_range(0, 7)),
                         $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
                1: issue(1'b1, 2'b10, 1'b0, 3'b000, $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
                2: begin
                    f3 = ld_f3[$urandom_range(0, 4)];
                    if ($urandom_range(0, 1) == 1) addr = addr - (addr % size_of(f3));
                    issue(1'b1, 2'b01, 1'b0, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3));
                end
                default: begin
                    f3 = 3'($urandom_range(0, 2));
                    if ($urandom_range(0, 1) == 1) addr = addr - (addr % size_of(f3));
                    issue(1'b0, 2'b00, 1'b1, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3));
                end
            endcase
        end

        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline M stage of the 5-stage RISC-V core: consumes the Execute pipeline outputs (RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM), runs loads and stores against a variable-latency data-memory port with a req/ready handshake, and registers results into the M/W pipeline register. It generates `Stall` back to the Execute pipeline register and Decode/Fetch while a memory access is outstanding. Sub-word loads are aligned and extended here; misaligned accesses are flagged and suppressed.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `RegWriteM` in 1: M instruction writes rd.
- `ResultSrcM` in 2: 00 ALU, 01 memory load, 10 PC+4 (passed through).
- `MemWriteM` in 1: M instruction is a store.
- `Funct3M` in 3: size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALUResultM` in 32: effective address or ALU result.
- `WriteDataM` in 32: store data (rs2, already forwarded).
- `RdM` in 5: destination register.
- `Stall` out 1: freeze F/D/E and the Execute pipeline register.
- `MisalignM` out 1: current M access is misaligned (combinational).
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: 1 store, 0 load.
- `mem_addr` out 32: `{ALUResultM[31:2], 2'b00}`.
- `mem_be` out 4: byte enables (stores; all-ones for loads).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: access completes this cycle; `mem_rdata` valid when load.
- `mem_rdata` in 32: aligned read word.
- `RegWriteW` out 1, `ResultSrcW` out 2, `ALUResultW` out 32, `ReadDataW` out 32, `RdW` out 5: M/W register.

## Operation
- Memory op: `memop = (ResultSrcM==01) | MemWriteM`; misaligned when H/HU with addr[0]=1, or W with addr[1:0]!=0.
- FSM: IDLE, WAIT.
  - IDLE: if memop & !MisalignM, assert `mem_req`; if `mem_ready` same cycle, complete (stay IDLE), else go WAIT.
  - WAIT: keep `mem_req` high, address/data/be unchanged (inputs frozen by Stall); on `mem_ready` complete, go IDLE.
- `Stall = memop & !MisalignM & !mem_ready` in either state; never asserted for non-memory ops or misaligned ops.
- Store lanes: B: wdata = {4{WriteDataM[7:0]}}, be = 0001 << addr[1:0]; H: wdata = {2{WriteDataM[15:0]}}, be = 0011 << addr[1:0]; W: be = 1111.
- Load extract: byte at mem_rdata[8*addr[1:0]+:8], half at mem_rdata[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W unchanged.
- M/W register update every edge:
  - Stall=1: bubble: RegWriteW=0, other W fields hold.
  - Misaligned: RegWriteW=0, remaining fields load normally; no bus activity, store not issued.
  - Otherwise load all fields; ReadDataW = extended load data (don't-care 0 for non-loads).
- `mem_we = MemWriteM`; `mem_req` qualified by state/reset only, never by `mem_ready`.

## Timing
- Reset (async): FSM IDLE; RegWriteW=0, ResultSrcW=00, ALUResultW=0, ReadDataW=0, RdW=0; `mem_req` forced 0 combinationally while rst high; Stall=0.
- Reset during WAIT: request abandoned immediately, no W write, FSM IDLE after release.
- Zero-wait access: 1 cycle in M, Stall never rises; result in W next edge.
- N-wait access (ready in the Nth cycle after req): Stall high N cycles, W bubbles N edges, result in W on the edge ending the ready cycle.
- Back-to-back memory ops: next op in M the cycle after completion; req may stay high continuously.
- `mem_ready` while `mem_req`=0 is ignored.
- Non-memory op: pure 1-cycle register, no bus activity.

## Test plan
- ALU op RdM=5, ALUResultM=0x1234, RegWriteM=1 -> next edge RdW=5, ALUResultW=0x1234, RegWriteW=1, mem_req never high.
- LW addr 0x100, ready same cycle, rdata 0xDEADBEEF -> Stall 0, ReadDataW=0xDEADBEEF next edge.
- LB addr 0x103, ready after 3 waits, rdata 0x80FFFFFF -> Stall high 3 cycles, RegWriteW=0 for 3 edges, then ReadDataW=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, WriteDataM=0xAAAA5555 -> mem_be=1100, mem_wdata=0x55555555, mem_we=1; SB addr 0x201 -> be=0010.
- LW addr 0x102 -> MisalignM=1, mem_req 0, Stall 0, RegWriteW=0.
- LW with ready withheld, assert rst mid-WAIT -> mem_req drops same cycle, all W outputs 0, IDLE after release.
